// File: rtl/pk_poci.sv
// Shared POCI LED peripheral definitions: register addresses and the
// register-select encoding used by requesters of the LED write scheduler.
package pk_poci;

  localparam int ADDR_W = 8;

  localparam logic [ADDR_W-1:0] addr_hex  = 8'h00;
  localparam logic [ADDR_W-1:0] addr_ledg = 8'h04;
  localparam logic [ADDR_W-1:0] addr_ledr = 8'h08;

  typedef enum logic [1:0] {
    SEL_HEX  = 2'd0,
    SEL_LEDG = 2'd1,
    SEL_LEDR = 2'd2,
    SEL_RSVD = 2'd3
  } led_sel_t;

  // Reserved select has no register; callers reject it before using the address.
  function automatic logic [ADDR_W-1:0] sel_to_addr(input led_sel_t sel);
    logic [ADDR_W-1:0] addr;
    case (sel)
      SEL_LEDG: addr = addr_ledg;
      SEL_LEDR: addr = addr_ledr;
      default:  addr = addr_hex;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/poci_led_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after
// ptr, wrapping modulo N. Usable by any POCI master that shares a slave.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/poci_led_sched.sv
// Round-robin write scheduler sharing one POCI LED slave among NREQ requesters;
// one SETUP/ACCESS write per grant, with ack/err pulses back to the requester.
//
// state  | meaning
// IDLE   | no transfer; arbitrate, reject reserved selects, or start a write
// SETUP  | psel=1, penable=0; address/data already latched
// ACCESS | psel=1, penable=1; wait for pready or timeout
module poci_led_sched
  import pk_poci::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   pclk,
  input  logic                   preset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0][1:0]   req_sel,
  input  logic [NREQ-1:0][31:0]  req_data,
  output logic [NREQ-1:0]        ack,
  output logic [NREQ-1:0]        err,
  output logic                   busy,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [ADDR_W-1:0]      paddr,
  output logic [31:0]            pwdata,
  input  logic                   pready,
  input  logic                   pslverr
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt;
  logic [CW-1:0] cnt;

  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] ptr_next;
  led_sel_t      win_sel;

  rr_arbiter #(
    .N(NREQ)
  ) u_arb (
    .req      (req),
    .ptr      (ptr),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  assign ptr_next = IW'((int'(gnt_idx) + 1) % NREQ);
  assign win_sel  = led_sel_t'(req_sel[gnt_idx]);

  always_ff @(posedge pclk) begin
    if (preset) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      gnt     <= '0;
      cnt     <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b1;
      paddr   <= '0;
      pwdata  <= '0;
      ack     <= '0;
      err     <= '0;
      busy    <= 1'b0;
    end else begin
      ack <= '0;
      err <= '0;
      unique case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            ptr <= ptr_next;
            if (win_sel == SEL_RSVD) begin
              err[gnt_idx] <= 1'b1;
            end else begin
              gnt    <= gnt_idx;
              paddr  <= sel_to_addr(win_sel);
              pwdata <= req_data[gnt_idx];
              psel   <= 1'b1;
              busy   <= 1'b1;
              state  <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          cnt     <= '0;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // pready on the last allowed cycle still completes normally
          if (pready || cnt == CNT_LAST) begin
            if (pready && !pslverr) begin
              ack[gnt] <= 1'b1;
            end else begin
              err[gnt] <= 1'b1;
            end
            psel    <= 1'b0;
            penable <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  a_resp_onehot : assert property (@(posedge pclk) disable iff (preset) $onehot0(ack | err));
  a_penable_psel : assert property (@(posedge pclk) disable iff (preset) penable |-> psel);

endmodule

// File: tb/tb_poci_led_sched.sv
// Bench for poci_led_sched: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_poci_led_sched;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic                  pclk = 1'b0;
  logic                  preset = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ-1:0][1:0]  req_sel = '0;
  logic [NREQ-1:0][31:0] req_data = '0;
  logic [NREQ-1:0]       ack, err;
  logic                  busy, psel, penable, pwrite;
  logic [7:0]            paddr;
  logic [31:0]           pwdata;
  logic                  pready = 1'b0;
  logic                  pslverr = 1'b0;

  poci_led_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .preset(preset), .req(req), .req_sel(req_sel), .req_data(req_data),
    .ack(ack), .err(err), .busy(busy), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (transaction view) ----------------
  logic [7:0] addr_tab [4] = '{8'h00, 8'h04, 8'h08, 8'h00};
  bit              m_active = 0;
  int              m_age = 0;      // 0 = setup cycle, k>=1 = k-th access cycle
  int              m_ptr = 0;
  int              m_g = 0;
  logic [7:0]      m_addr = '0;
  logic [31:0]     m_data = '0;
  logic [NREQ-1:0] m_ack = '0, m_err = '0;

  always @(posedge pclk) begin
    m_ack = '0;
    m_err = '0;
    if (preset) begin
      m_active = 0; m_ptr = 0; m_age = 0;
    end else if (m_active) begin
      if (m_age == 0) m_age = 1;
      else if (pready) begin
        if (pslverr) m_err[m_g] = 1'b1; else m_ack[m_g] = 1'b1;
        m_active = 0;
      end else if (m_age == TIMEOUT) begin
        m_err[m_g] = 1'b1;
        m_active = 0;
      end else m_age++;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (req[i]) begin
          m_ptr = (i + 1) % NREQ;
          if (req_sel[i] == 2'd3) m_err[i] = 1'b1;
          else begin
            m_active = 1; m_age = 0; m_g = i;
            m_addr = addr_tab[req_sel[i]];
            m_data = req_data[i];
          end
          break;
        end
      end
    end
  end

  always @(negedge pclk) begin
    if (chk_en) begin
      chk("psel", psel, m_active);
      chk("penable", penable, m_active && m_age >= 1);
      chk("busy", busy, m_active);
      chk("pwrite", pwrite, 1);
      chk("ack", ack, m_ack);
      chk("err", err, m_err);
      if (m_active) begin
        chk("paddr", paddr, m_addr);
        chk("pwdata", pwdata, m_data);
      end
    end
  end

  // ---------------- LED slave ----------------
  logic [31:0] led_hex = '0, led_ledg = '0, led_ledr = '0;
  bit sl_mode = 0;      // 0: fixed wait/err, 1: random per transfer
  int sl_w = 0;
  bit sl_e = 0;
  bit in_acc = 0;
  int acc_k = 0;
  int cur_w = 0;
  bit cur_e = 0;

  always @(posedge pclk) begin
    if (psel && penable && pready && !pslverr) begin
      case (paddr)
        8'h00: led_hex  <= pwdata;
        8'h04: led_ledg <= pwdata;
        8'h08: led_ledr <= pwdata;
        default: ;
      endcase
    end
  end

  task automatic slave_update();
    if (psel && penable) begin
      if (!in_acc) begin
        in_acc = 1; acc_k = 0;
        if (sl_mode) begin
          int r;
          r = $urandom_range(0, 99);
          if (r < 60) cur_w = $urandom_range(0, 2);
          else if (r < 80) cur_w = $urandom_range(3, 14);
          else if (r < 88) cur_w = 15;
          else if (r < 94) cur_w = 16;
          else cur_w = 40;
          cur_e = ($urandom_range(0, 5) == 0);
        end else begin
          cur_w = sl_w; cur_e = sl_e;
        end
      end else acc_k++;
      pready  = (acc_k == cur_w);
      pslverr = pready ? cur_e : (sl_mode ? 1'($urandom_range(0, 1)) : 1'b0);
    end else begin
      in_acc = 0;
      pready  = sl_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      pslverr = sl_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  // ---------------- requesters ----------------
  logic [NREQ-1:0] pending = '0;
  bit hold = 0;
  bit rand_on = 0;

  task automatic req_update();
    for (int i = 0; i < NREQ; i++) begin
      if ((ack[i] || err[i]) && !hold) begin
        pending[i] = 1'b0;
        req[i] = 1'b0;
      end
    end
    if (rand_on) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pending[i] && req[i] && m_active && m_g == i && $urandom_range(0, 9) == 0)
          req[i] = 1'b0;
        if (!pending[i] && $urandom_range(0, 3) == 0) begin
          pending[i] = 1'b1;
          req[i] = 1'b1;
          req_sel[i] = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
          req_data[i] = $urandom;
        end
      end
      if ($urandom_range(0, 299) == 0) preset = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
    cyc++;
    if (preset) begin
      preset = 1'b0;
      req = pending;
    end
    slave_update();
    req_update();
  endtask

  task automatic do_reset();
    req = '0; pending = '0;
    preset = 1'b1;
    tick();
  endtask

  task automatic raise(input int i, input logic [1:0] sel, input logic [31:0] data);
    req_sel[i] = sel; req_data[i] = data; req[i] = 1'b1; pending[i] = 1'b1;
  endtask

  task automatic wait_resp(input int maxc, output int idx, output bit is_ack, output int at);
    idx = -1; is_ack = 0; at = cyc;
    for (int n = 0; n < maxc; n++) begin
      tick();
      if (|(ack | err)) begin
        for (int i = 0; i < NREQ; i++) if (ack[i] || err[i]) idx = i;
        is_ack = |ack;
        at = cyc;
        return;
      end
    end
    n_checks++; n_err++;
    $display("FAIL wait_resp: no response within %0d cycles (cycle %0d)", maxc, cyc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, at, t0, cnt;
    bit is_ack;
    int order [5];
    int times [5];

    // reset values
    tick();
    tick();
    chk_en = 1;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 1);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_ack_err", {ack, err}, 0);
    chk("rst_busy", busy, 0);

    // single write, zero-wait slave
    sl_mode = 0; sl_w = 0; sl_e = 0;
    raise(0, 2'd1, 32'h0000_00A5);
    tick();
    chk("single_setup_psel", {psel, penable}, 2'b10);
    chk("single_paddr", paddr, 8'h04);
    chk("single_pwdata", pwdata, 32'hA5);
    tick();
    chk("single_access", {psel, penable}, 2'b11);
    tick();
    chk("single_ack_at_3", ack, 4'b0001);
    chk("single_no_err", err, 4'b0000);
    cnt = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (ack[0]) cnt++;
    end
    chk("single_ack_once", cnt, 0);
    chk("single_ledg", led_ledg, 32'hA5);

    // round-robin with all requests held
    do_reset();
    hold = 1;
    for (int i = 0; i < NREQ; i++) raise(i, 2'd0, 32'h100 + i);
    t0 = cyc;
    for (int k = 0; k < 5; k++) begin
      wait_resp(20, idx, is_ack, at);
      order[k] = idx; times[k] = at;
    end
    req = '0; pending = '0; hold = 0;
    chk("rr_order0", order[0], 0);
    chk("rr_order1", order[1], 1);
    chk("rr_order2", order[2], 2);
    chk("rr_order3", order[3], 3);
    chk("rr_order4", order[4], 0);
    chk("rr_first_latency", times[0] - t0, 3);
    for (int k = 1; k < 5; k++) chk("rr_period", times[k] - times[k-1], 3);
    tick(); tick();

    // slave error
    sl_w = 1; sl_e = 1;
    raise(2, 2'd2, 32'hDEAD_0002);
    wait_resp(30, idx, is_ack, at);
    chk("slverr_idx", idx, 2);
    chk("slverr_err", err, 4'b0100);
    chk("slverr_no_ack", ack, 4'b0000);
    chk("slverr_idle", {psel, busy}, 2'b00);

    // timeout
    sl_w = 1000; sl_e = 0;
    raise(3, 2'd2, 32'h1234_5678);
    cnt = 0;
    idx = -1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (|err) begin idx = n; break; end
      if (psel && penable) cnt++;
    end
    chk("timeout_seen", idx >= 0, 1);
    chk("timeout_access_cycles", cnt, TIMEOUT);
    chk("timeout_err", err, 4'b1000);
    chk("timeout_psel_low", psel, 0);
    sl_w = 0;
    tick();

    // reserved select
    do_reset();
    raise(1, 2'd3, 32'hFFFF_FFFF);
    tick();
    chk("rsvd_err", err, 4'b0010);
    chk("rsvd_psel", psel, 0);
    tick();
    chk("rsvd_psel_after", psel, 0);
    raise(0, 2'd0, 32'h11);
    raise(2, 2'd0, 32'h22);
    wait_resp(20, idx, is_ack, at);
    chk("rsvd_ptr_advanced", idx, 2);
    wait_resp(20, idx, is_ack, at);
    chk("rsvd_next", idx, 0);
    tick();

    // reset in the middle of ACCESS
    do_reset();
    sl_w = 1000;
    raise(1, 2'd1, 32'hAA);
    raise(3, 2'd1, 32'hBB);
    idx = -1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (psel && penable) begin idx = n; break; end
    end
    chk("midrst_reached_access", idx >= 0, 1);
    preset = 1'b1;
    sl_w = 0;
    tick();
    chk("midrst_bus", {psel, penable, busy}, 3'b000);
    chk("midrst_no_resp", {ack, err}, 0);
    wait_resp(20, idx, is_ack, at);
    chk("midrst_regrant_from0", idx, 1);
    wait_resp(20, idx, is_ack, at);
    chk("midrst_second", idx, 3);
    tick(); tick();

    // randomized traffic
    sl_mode = 1;
    rand_on = 1;
    for (int n = 0; n < 3000; n++) tick();
    rand_on = 0;
    for (int n = 0; n < 400; n++) tick();
    chk("drain_pending", pending, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
